// File: rtl/alu_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_buffer
// Purpose  : 2-entry skid buffer for ALU results and flags ahead of writeback.
//            Define ALU_RESULT_FWD_EN to add the pending-result lookup port.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_buffer #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_result,
    input  logic                      in_zero,
    input  logic                      in_carry,
    input  logic                      in_overflow,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic                      in_we,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_result,
    output logic                      out_zero,
    output logic                      out_carry,
    output logic                      out_overflow,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic                      out_we,
    output logic [1:0]                occupancy
`ifdef ALU_RESULT_FWD_EN
    ,
    input  logic [REG_ADDR_WIDTH-1:0] fwd_rs,
    output logic                      fwd_hit,
    output logic [DATA_WIDTH-1:0]     fwd_data
`endif
);

    // Entry layout, LSB first: we, rd, overflow, carry, zero, result
    localparam int ENTRY_W = DATA_WIDTH + REG_ADDR_WIDTH + 4;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    logic [ENTRY_W-1:0] head_q, head_d;
    logic [ENTRY_W-1:0] skid_q, skid_d;
    logic [1:0]         occ_q, occ_d;
    logic [ENTRY_W-1:0] in_entry;
    logic               in_we_eff;
    logic               do_accept;
    logic               do_release;

    // Writes to x0 are neutralised at capture so they are never seen downstream
    assign in_we_eff = in_we && (in_rd != '0);
    assign in_entry  = {in_result, in_zero, in_carry, in_overflow, in_rd, in_we_eff};

    assign in_ready   = (occ_q != OCC_FULL);
    assign out_valid  = (occ_q != OCC_EMPTY);
    assign occupancy  = occ_q;
    assign do_accept  = in_valid && in_ready;
    assign do_release = out_valid && out_ready;

    assign {out_result, out_zero, out_carry, out_overflow, out_rd, out_we} = head_q;

    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        occ_d  = occ_q;
        if (flush) begin
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (do_accept) begin
                        head_d = in_entry;
                        occ_d  = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (do_accept && !do_release) begin
                        skid_d = in_entry;
                        occ_d  = OCC_FULL;
                    end else if (do_accept && do_release) begin
                        head_d = in_entry;
                    end else if (do_release) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (do_release) begin
                        head_d = skid_q;
                        occ_d  = OCC_ONE;
                    end
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            skid_q <= '0;
            occ_q  <= OCC_EMPTY;
        end else begin
            head_q <= head_d;
            skid_q <= skid_d;
            occ_q  <= occ_d;
        end
    end

`ifdef ALU_RESULT_FWD_EN
    logic hit_head;
    logic hit_skid;

    // Skid holds the younger entry, so it wins when both match
    always_comb begin
        hit_head = (occ_q != OCC_EMPTY) && head_q[0] && (head_q[REG_ADDR_WIDTH:1] == fwd_rs);
        hit_skid = (occ_q == OCC_FULL) && skid_q[0] && (skid_q[REG_ADDR_WIDTH:1] == fwd_rs);
        fwd_hit  = hit_head || hit_skid;
        if (hit_skid) begin
            fwd_data = skid_q[ENTRY_W-1 -: DATA_WIDTH];
        end else if (hit_head) begin
            fwd_data = head_q[ENTRY_W-1 -: DATA_WIDTH];
        end else begin
            fwd_data = '0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_buffer
// Purpose  : Scoreboard bench for alu_result_buffer (ALU_RESULT_FWD_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_buffer;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        o;
        logic [4:0]  rd;
        logic        we;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_result = '0;
    logic        in_zero = 1'b0;
    logic        in_carry = 1'b0;
    logic        in_overflow = 1'b0;
    logic [4:0]  in_rd = '0;
    logic        in_we = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_carry;
    logic        out_overflow;
    logic [4:0]  out_rd;
    logic        out_we;
    logic [1:0]  occupancy;
`ifdef ALU_RESULT_FWD_EN
    logic [4:0]  fwd_rs = '0;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    alu_result_buffer #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_zero      (in_zero),
        .in_carry     (in_carry),
        .in_overflow  (in_overflow),
        .in_rd        (in_rd),
        .in_we        (in_we),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_rd       (out_rd),
        .out_we       (out_we),
        .occupancy    (occupancy)
`ifdef ALU_RESULT_FWD_EN
        ,
        .fwd_rs       (fwd_rs),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input logic v, input logic [31:0] r, input logic z,
                            input logic c, input logic o, input logic [4:0] rd, input logic we);
        in_valid    = v;
        in_result   = r;
        in_zero     = z;
        in_carry    = c;
        in_overflow = o;
        in_rd       = rd;
        in_we       = we;
    endtask

    task automatic alu_beat(input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic we);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        set_beat(1'b1, s[31:0], s[31:0] == 32'h0, s[32],
                 (a[31] == b[31]) && (s[31] != a[31]), rd, we);
    endtask

    // Called at a negedge with inputs already driven: scores the coming edge, then
    // advances to the next negedge.
    task automatic step();
        ent_t obs;
        ent_t exp;
        obs = {out_result, out_zero, out_carry, out_overflow, out_rd, out_we};
        if (flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", {22'h0, obs}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp = q.pop_front();
                    check("out_entry", {22'h0, obs}, {22'h0, exp});
                end
            end
            if (in_valid && in_ready) begin
                exp = '{r: in_result, z: in_zero, c: in_carry, o: in_overflow,
                        rd: in_rd, we: in_we && (in_rd != 5'd0)};
                q.push_back(exp);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && q.size() > 0; i++) step();
        check("drain_queue_empty", 64'(q.size()), 64'd0);
        check("drain_out_valid", {63'h0, out_valid}, 64'd0);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_occupancy", {62'h0, occupancy}, 64'd0);
        check("rst_out_valid", {63'h0, out_valid}, 64'd0);
        check("rst_in_ready", {63'h0, in_ready}, 64'd1);
        check("rst_out_data", {22'h0, out_result, out_zero, out_carry, out_overflow, out_rd, out_we}, 64'd0);
`ifdef ALU_RESULT_FWD_EN
        check("rst_fwd", {31'h0, fwd_hit, fwd_data}, 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            alu_beat($urandom, (i % 50 == 0) ? 32'h0 - 32'(i) : $urandom,
                     5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            check("stream_in_ready", {63'h0, in_ready}, 64'd1);
            check("stream_occ_le1", {63'h0, occupancy > 2'd1}, 64'd0);
            if (i > 0) check("stream_out_valid", {63'h0, out_valid}, 64'd1);
            step();
        end
        drain();

        // Fill to two entries, then release once
        out_ready = 1'b0;
        set_beat(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1);
        step();
        set_beat(1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1);
        step();
        in_valid = 1'b0;
        check("full_in_ready", {63'h0, in_ready}, 64'd0);
        check("full_occupancy", {62'h0, occupancy}, 64'd2);
        check("full_head_stable", {32'h0, out_result}, 64'h11);
        step();
        check("full_hold_result", {32'h0, out_result}, 64'h11);
        out_ready = 1'b1;
        step();
        check("after_rel_result", {32'h0, out_result}, 64'h22);
        check("after_rel_in_ready", {63'h0, in_ready}, 64'd1);
        check("after_rel_occ", {62'h0, occupancy}, 64'd1);
        drain();

        // Write to x0 is neutralised
        out_ready = 1'b0;
        set_beat(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        step();
        in_valid = 1'b0;
        check("x0_out_we", {63'h0, out_we}, 64'd0);
        check("x0_out_result", {32'h0, out_result}, 64'hDEADBEEF);
`ifdef ALU_RESULT_FWD_EN
        fwd_rs = 5'd0;
        #1;
        check("x0_fwd_hit", {63'h0, fwd_hit}, 64'd0);
`endif
        drain();

`ifdef ALU_RESULT_FWD_EN
        // Youngest pending value wins
        out_ready = 1'b0;
        set_beat(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1);
        step();
        set_beat(1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1);
        step();
        in_valid = 1'b0;
        fwd_rs = 5'd5;
        #1;
        check("fwd_hit_rd5", {63'h0, fwd_hit}, 64'd1);
        check("fwd_data_rd5", {32'h0, fwd_data}, 64'h2);
        fwd_rs = 5'd6;
        #1;
        check("fwd_miss_rd6", {31'h0, fwd_hit, fwd_data}, 64'd0);
        drain();
        fwd_rs = 5'd5;
        #1;
        check("fwd_empty_miss", {63'h0, fwd_hit}, 64'd0);
`endif

        // Flush at occupancy 2 with a simultaneous beat
        out_ready = 1'b0;
        set_beat(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1);
        step();
        set_beat(1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1);
        step();
        check("pre_flush_occ", {62'h0, occupancy}, 64'd2);
        out_ready = 1'b1;
        flush = 1'b1;
        set_beat(1'b1, 32'h99, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_occ", {62'h0, occupancy}, 64'd0);
        check("flush_out_valid", {63'h0, out_valid}, 64'd0);
        set_beat(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1);
        step();
        drain();

        // Asynchronous reset at occupancy 2
        out_ready = 1'b0;
        set_beat(1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1);
        step();
        set_beat(1'b1, 32'h77, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1);
        step();
        in_valid = 1'b0;
        check("pre_rst_occ", {62'h0, occupancy}, 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {63'h0, out_valid}, 64'd0);
        check("arst_in_ready", {63'h0, in_ready}, 64'd1);
        check("arst_occ", {62'h0, occupancy}, 64'd0);
        check("arst_out_result", {32'h0, out_result}, 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", {63'h0, out_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
